// File: rtl/fixed_exp_pkg.sv
// fixed_exp_pkg: shared widths, FSM state type and constant table for the
// shift-and-add exp(x) core.
//   IN_W/IN_FRAC   : input x format (signed Q3.7)
//   OUT_W/OUT_FRAC : output format (unsigned Q5.5)
//   FRAC_W         : fraction bits of the residual z and accumulator y
//   LN_TBL[k]      : ln(1 + 2^-k) rounded to FRAC_W fraction bits
package fixed_exp_pkg;

  localparam int unsigned IN_W     = 10;
  localparam int unsigned OUT_W    = 10;
  localparam int unsigned IN_FRAC  = 7;
  localparam int unsigned OUT_FRAC = 5;
  localparam int unsigned FRAC_W   = 16;
  localparam int unsigned N_INT    = 6;
  localparam int unsigned N_FRAC   = 15;

  // Residual z: sign + 3 integer bits; init can briefly reach ~4.16.
  localparam int unsigned Z_W   = FRAC_W + 4;
  // Accumulator y: unsigned Q6.FRAC_W, always below 64.
  localparam int unsigned Y_W   = FRAC_W + 6;
  localparam int unsigned K_W   = 4;
  localparam int unsigned CNT_W = 4;

  // round(6 * ln2 * 2^FRAC_W)
  localparam int unsigned SIX_LN2 = 272557;

  typedef enum logic [1:0] {
    IDLE,
    INT,
    FRAC,
    DONE
  } state_t;

  localparam logic [FRAC_W-1:0] LN_TBL [16] = '{
    16'd45426, 16'd26573, 16'd14624, 16'd7719,
    16'd3973,  16'd2017,  16'd1016,  16'd510,
    16'd256,   16'd128,   16'd64,    16'd32,
    16'd16,    16'd8,     16'd4,     16'd2
  };

endpackage

// File: rtl/fixed_exp_step.sv
// fixed_exp_step: one multiplicative-normalization iteration.
//   z        : current residual exponent (non-negative)
//   y        : current accumulator, Q6.FRAC_W
//   k        : iteration index (shift amount)
//   l        : ln(1 + 2^-k)
//   z_next_c : residual after the step
//   y_next_c : accumulator after the step
module fixed_exp_step
  import fixed_exp_pkg::*;
(
  input  logic [Z_W-1:0]    z,
  input  logic [Y_W-1:0]    y,
  input  logic [K_W-1:0]    k,
  input  logic [FRAC_W-1:0] l,
  output logic [Z_W-1:0]    z_next_c,
  output logic [Y_W-1:0]    y_next_c
);

  logic take_c;

  // Consume ln(1+2^-k) from z when it fits and scale y by (1+2^-k).
  always_comb begin
    take_c   = (z >= Z_W'(l));
    z_next_c = z;
    y_next_c = y;
    if (take_c) begin
      z_next_c = z - Z_W'(l);
      y_next_c = y + (y >> k);
    end
  end

endmodule

// File: rtl/fixed_exp.sv
// fixed_exp: iterative exp(x) core, one conversion every 23 clocks.
//   SW       : x, signed Q3.7
//   LEDR     : exp(x), unsigned Q5.5, registered, saturated at 1023
//   CLOCK_50 : clock, rising edge
//   reset    : synchronous active-high reset
module fixed_exp
  import fixed_exp_pkg::*;
(
  input  logic [IN_W-1:0]  SW,
  output logic [OUT_W-1:0] LEDR,
  input  logic             CLOCK_50,
  input  logic             reset
);

  localparam int unsigned SHIFT_IN  = FRAC_W - IN_FRAC;
  localparam int unsigned SIGN_EXT  = Z_W - IN_W - SHIFT_IN;
  localparam int unsigned SHIFT_OUT = FRAC_W - OUT_FRAC;
  localparam int unsigned RND       = 1 << (SHIFT_OUT - 1);
  localparam int unsigned SH_W      = Y_W + 1 - SHIFT_OUT;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [IN_W-1:0]    x_q;
  logic [Z_W-1:0]     z;
  logic [Y_W-1:0]     y;

  logic               first_c;
  logic [Z_W-1:0]     x_ext_c;
  logic [Z_W-1:0]     z_init_c;
  logic [Y_W-1:0]     y_init_c;
  logic [Z_W-1:0]     z_in_c;
  logic [Y_W-1:0]     y_in_c;
  logic [K_W-1:0]     k_c;
  logic [FRAC_W-1:0]  l_c;
  logic [Z_W-1:0]     z_next_c;
  logic [Y_W-1:0]     y_next_c;
  logic [Y_W:0]       sum_c;
  logic [SH_W-1:0]    sh_c;
  logic [OUT_W-1:0]   out_c;

  // Range reduction: negative x is lifted by 6*ln2 and y pre-scaled by 2^-6,
  // so z stays non-negative for the whole run. Folded into the first INT step.
  always_comb begin
    first_c  = (state == INT) && (cnt == '0);
    x_ext_c  = {{SIGN_EXT{x_q[IN_W-1]}}, x_q, {SHIFT_IN{1'b0}}};
    z_init_c = x_q[IN_W-1] ? x_ext_c + Z_W'(SIX_LN2) : x_ext_c;
    y_init_c = x_q[IN_W-1] ? Y_W'(1) << (FRAC_W - N_INT) : Y_W'(1) << FRAC_W;
    z_in_c   = first_c ? z_init_c : z;
    y_in_c   = first_c ? y_init_c : y;
    k_c      = (state == INT) ? '0 : K_W'(cnt);
    l_c      = LN_TBL[k_c];
  end

  fixed_exp_step u_step (
    .z        (z_in_c),
    .y        (y_in_c),
    .k        (k_c),
    .l        (l_c),
    .z_next_c (z_next_c),
    .y_next_c (y_next_c)
  );

  // Round half up to Q5.5, saturating anything that needs more than OUT_W bits.
  always_comb begin
    sum_c = {1'b0, y} + (Y_W + 1)'(RND);
    sh_c  = SH_W'(sum_c >> SHIFT_OUT);
    out_c = (|sh_c[SH_W-1:OUT_W]) ? '1 : sh_c[OUT_W-1:0];
  end

  // Control FSM and datapath registers.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      x_q   <= '0;
      z     <= '0;
      y     <= '0;
      LEDR  <= '0;
    end else begin
      case (state)
        IDLE: begin
          x_q   <= SW;
          cnt   <= '0;
          state <= INT;
        end
        INT: begin
          z <= z_next_c;
          y <= y_next_c;
          if (cnt == CNT_W'(N_INT - 1)) begin
            cnt   <= CNT_W'(1);
            state <= FRAC;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        FRAC: begin
          z <= z_next_c;
          y <= y_next_c;
          if (cnt == CNT_W'(N_FRAC)) begin
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          LEDR  <= out_c;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_exp.sv
// tb_fixed_exp: directed and random checks of the fixed_exp core.
module tb_fixed_exp;

  logic       clk;
  logic       reset;
  logic [9:0] sw;
  logic [9:0] ledr;

  int n_checks;
  int n_fail;

  fixed_exp dut (
    .SW       (sw),
    .LEDR     (ledr),
    .CLOCK_50 (clk),
    .reset    (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Precondition: the next rising edge is an IDLE capture edge.
  task automatic run_conv(input logic [9:0] x, output logic [9:0] res);
    sw = x;
    repeat (23) @(posedge clk);
    #1;
    res = ledr;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (ledr !== 10'd0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got %0d expected 0", i, ledr);
      end
    end
    reset = 1'b0;
    repeat (22) @(posedge clk);
    #1;
    n_checks++;
    if (ledr !== 10'd0) begin
      n_fail++;
      $display("FAIL latency_early: got %0d expected 0", ledr);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (ledr !== 10'd87) begin
      n_fail++;
      $display("FAIL latency_first: got %0d expected 87", ledr);
    end
  endtask

  task automatic test_basic;
    logic [9:0] r;
    run_conv(10'd128, r);
    n_checks++;
    if (r !== 10'd87) begin
      n_fail++;
      $display("FAIL exp_one: got %0d expected 87", r);
    end
    run_conv(10'd0, r);
    n_checks++;
    if (r !== 10'd32) begin
      n_fail++;
      $display("FAIL exp_zero: got %0d expected 32", r);
    end
  endtask

  task automatic test_saturation;
    logic [9:0] r;
    run_conv(10'd443, r);
    n_checks++;
    if (r < 10'd1018 || r > 10'd1020) begin
      n_fail++;
      $display("FAIL exp_443: got %0d expected 1019 +/-1", r);
    end
    run_conv(10'd511, r);
    n_checks++;
    if (r !== 10'd1023) begin
      n_fail++;
      $display("FAIL exp_sat: got %0d expected 1023", r);
    end
  endtask

  task automatic test_negative;
    logic [9:0] r;
    run_conv(10'h380, r);
    n_checks++;
    if (r !== 10'd12) begin
      n_fail++;
      $display("FAIL exp_m1: got %0d expected 12", r);
    end
    run_conv(10'h200, r);
    n_checks++;
    if (r !== 10'd1) begin
      n_fail++;
      $display("FAIL exp_m4: got %0d expected 1", r);
    end
  endtask

  task automatic test_sw_change;
    logic [9:0] r;
    sw = 10'd128;
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (ledr !== 10'd1) begin
      n_fail++;
      $display("FAIL hold_prev: got %0d expected 1", ledr);
    end
    sw = 10'd256;
    repeat (13) @(posedge clk);
    #1;
    n_checks++;
    if (ledr !== 10'd87) begin
      n_fail++;
      $display("FAIL sw_ignored: got %0d expected 87", ledr);
    end
    run_conv(10'd256, r);
    n_checks++;
    if (r < 10'd235 || r > 10'd237) begin
      n_fail++;
      $display("FAIL exp_two: got %0d expected 236 +/-1", r);
    end
  endtask

  task automatic test_random;
    logic [9:0] r;
    logic [9:0] x;
    int         expv;
    int         diff;
    for (int i = 0; i < 1000; i++) begin
      x = 10'($urandom_range(443, 0));
      run_conv(x, r);
      expv = int'($exp(real'(x) / 128.0) * 32.0);
      diff = int'(r) - expv;
      n_checks++;
      if (diff > 1 || diff < -1) begin
        n_fail++;
        $display("FAIL random[%0d] x=%0d: got %0d expected %0d +/-1", i, x, r, expv);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [9:0] r;
    sw = 10'd128;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (ledr !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got %0d expected 0", ledr);
    end
    reset = 1'b0;
    run_conv(10'd0, r);
    n_checks++;
    if (r !== 10'd32) begin
      n_fail++;
      $display("FAIL restart_zero: got %0d expected 32", r);
    end
    run_conv(10'd128, r);
    n_checks++;
    if (r !== 10'd87) begin
      n_fail++;
      $display("FAIL restart_one: got %0d expected 87", r);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    sw       = 10'd128;
    test_reset();
    test_basic();
    test_saturation();
    test_negative();
    test_sw_change();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
